// File: rtl/run_splitter_2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : run_splitter_2_pkg
// Purpose  : Shared types and constants for the run splitter: FSM states,
//            output-select encoding and the end-of-run terminator beat.
// Revision : 1.0 - initial release
// ============================================================================
package run_splitter_2_pkg;

  // Splitter FSM: PASS moves data beats, TERM injects a terminator.
  typedef enum logic [0:0] {
    ST_PASS = 1'b0,
    ST_TERM = 1'b1
  } state_e;

  // Which output FIFO currently receives the run being built.
  typedef enum logic [0:0] {
    SEL_1 = 1'b0,
    SEL_2 = 1'b1
  } sel_e;

  // Input skid depth; sized to absorb the two late writes after ready falls.
  localparam int c_skid_depth = 4;

  // Terminator is an all-zero tuple; any KEY_WIDTH slice of it is key 0.
  localparam int c_max_data_width = 4096;
  localparam logic [c_max_data_width-1:0] c_term_beat = '0;

  function automatic sel_e other_sel(input sel_e s);
    return (s == SEL_1) ? SEL_2 : SEL_1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/run_splitter_2_if.sv
`default_nettype none
// ============================================================================
// Module   : run_splitter_2_if
// Purpose  : Upstream write/ready bus plus the two FWFT empty/read output
//            ports of the run splitter, with splitter (slave) and
//            driver (master) views.
// Revision : 1.0 - initial release
// ============================================================================
interface run_splitter_2_if #(
  parameter int DATA_WIDTH = 256
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_write;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_fifo_1;
  logic                  o_fifo_1_empty;
  logic                  i_fifo_1_read;
  logic [DATA_WIDTH-1:0] o_fifo_2;
  logic                  o_fifo_2_empty;
  logic                  i_fifo_2_read;
  logic                  o_overrun;

  modport slave (
    input  i_data, i_write, i_fifo_1_read, i_fifo_2_read,
    output o_ready, o_fifo_1, o_fifo_1_empty, o_fifo_2, o_fifo_2_empty, o_overrun
  );

  modport master (
    output i_data, i_write, i_fifo_1_read, i_fifo_2_read,
    input  o_ready, o_fifo_1, o_fifo_1_empty, o_fifo_2, o_fifo_2_empty, o_overrun
  );
endinterface
`default_nettype wire

// File: rtl/run_splitter_2_split_fifo.sv
`default_nettype none
// ============================================================================
// Module   : split_fifo
// Purpose  : First-word-fall-through synchronous FIFO. Head is visible while
//            not empty; pushes when full and pops when empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module split_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit separates full (MSBs differ) from empty (all equal).
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_count = wr_ptr_q - rd_ptr_q;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Head reads as zero while empty so the port is clean after reset.
  assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; wrap falls out of the modulo-2*DEPTH counter width.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge i_clk) begin
    if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/run_splitter_2.sv
`default_nettype none
// ============================================================================
// Module   : run_splitter_2
// Purpose  : Cuts one tuple stream into RUN_LEN-beat runs, closes each run
//            with an all-zero terminator, and alternates runs between two
//            FWFT output FIFOs for the next merge pass.
// Revision : 1.0 - initial release
// ============================================================================
module run_splitter_2
  import run_splitter_2_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int KEY_WIDTH  = 32,
  parameter int RUN_LEN    = 8,
  parameter int DEPTH      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  run_splitter_2_if.slave  bus
);
  localparam int CNT_W   = $clog2(RUN_LEN + 1);
  localparam int SKID_CW = $clog2(c_skid_depth) + 1;
  localparam int OUT_CW  = $clog2(DEPTH) + 1;
  localparam int NEXT_W  = SKID_CW + 1;

  logic [DATA_WIDTH-1:0] w_skid_head;
  logic                  w_skid_empty;
  logic                  w_skid_full;
  logic [SKID_CW-1:0]    w_skid_count;
  logic                  w_skid_push;
  logic                  w_skid_pop;
  logic [NEXT_W-1:0]     w_skid_next;

  logic [DATA_WIDTH-1:0] w_f1_data;
  logic [DATA_WIDTH-1:0] w_f2_data;
  logic                  w_f1_empty;
  logic                  w_f2_empty;
  logic                  w_f1_full;
  logic                  w_f2_full;
  logic [OUT_CW-1:0]     w_f1_count;
  logic [OUT_CW-1:0]     w_f2_count;
  logic                  w_unused_counts;

  logic [DATA_WIDTH-1:0] w_out_data;
  logic                  w_active_full;
  logic                  w_move;
  logic                  w_term_push;
  logic                  w_push_1;
  logic                  w_push_2;
  logic                  w_key_zero;

  state_e                state_q;
  sel_e                  active_q;
  logic [CNT_W-1:0]      count_q;
  logic                  ready_q;
  logic                  overrun_q;

  // A write into a full skid is dropped (and flagged as overrun below).
  assign w_skid_push   = bus.i_write & ~w_skid_full;

  // Only the FIFO receiving the current run can stall the splitter.
  assign w_active_full = (active_q == SEL_1) ? w_f1_full : w_f2_full;
  assign w_move        = (state_q == ST_PASS) && !w_skid_empty && !w_active_full;
  assign w_term_push   = (state_q == ST_TERM) && !w_active_full;
  assign w_skid_pop    = w_move;
  assign w_key_zero    = (w_skid_head[KEY_WIDTH-1:0] == '0);
  assign w_out_data    = (state_q == ST_TERM) ? c_term_beat[DATA_WIDTH-1:0] : w_skid_head;
  assign w_push_1      = (w_move || w_term_push) && (active_q == SEL_1);
  assign w_push_2      = (w_move || w_term_push) && (active_q == SEL_2);

  // Skid occupancy after the coming edge, used to pre-compute ready.
  assign w_skid_next   = {1'b0, w_skid_count} + NEXT_W'(w_skid_push) - NEXT_W'(w_skid_pop);

  // Output FIFO occupancy is exposed by the FIFO but not needed here.
  assign w_unused_counts = &{1'b0, w_f1_count, w_f2_count};

  split_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(c_skid_depth)) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_skid_push),
    .i_data  (bus.i_data),
    .i_pop   (w_skid_pop),
    .o_data  (w_skid_head),
    .o_empty (w_skid_empty),
    .o_full  (w_skid_full),
    .o_count (w_skid_count)
  );

  split_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push_1),
    .i_data  (w_out_data),
    .i_pop   (bus.i_fifo_1_read),
    .o_data  (w_f1_data),
    .o_empty (w_f1_empty),
    .o_full  (w_f1_full),
    .o_count (w_f1_count)
  );

  split_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push_2),
    .i_data  (w_out_data),
    .i_pop   (bus.i_fifo_2_read),
    .o_data  (w_f2_data),
    .o_empty (w_f2_empty),
    .o_full  (w_f2_full),
    .o_count (w_f2_count)
  );

  // Run FSM: count data beats, close a run early on a key-0 beat, or insert
  // a terminator once RUN_LEN beats have gone out; then switch outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_PASS;
      active_q <= SEL_1;
      count_q  <= '0;
    end else begin
      case (state_q)
        ST_PASS: begin
          if (w_move) begin
            if (w_key_zero) begin
              active_q <= other_sel(active_q);
              count_q  <= '0;
            end else if (count_q == CNT_W'(RUN_LEN - 1)) begin
              state_q  <= ST_TERM;
              count_q  <= CNT_W'(RUN_LEN);
            end else begin
              count_q  <= count_q + 1'b1;
            end
          end
        end
        ST_TERM: begin
          if (!w_active_full) begin
            state_q  <= ST_PASS;
            active_q <= other_sel(active_q);
            count_q  <= '0;
          end
        end
        default: state_q <= ST_PASS;
      endcase
    end
  end

  // Registered ready (skid holds at most one beat) and sticky overrun flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ready_q   <= (w_skid_next <= NEXT_W'(1));
      overrun_q <= overrun_q | (bus.i_write & w_skid_full);
    end
  end

  assign bus.o_ready        = ready_q;
  assign bus.o_overrun      = overrun_q;
  assign bus.o_fifo_1       = w_f1_data;
  assign bus.o_fifo_1_empty = w_f1_empty;
  assign bus.o_fifo_2       = w_f2_data;
  assign bus.o_fifo_2_empty = w_f2_empty;

endmodule
`default_nettype wire

// File: tb/tb_run_splitter_2.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_splitter_2
// Purpose  : Self-checking bench for run_splitter_2 (RUN_LEN=4, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_splitter_2;
  localparam int DW = 64;
  localparam int KW = 16;
  localparam int RL = 4;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  run_splitter_2_if #(.DATA_WIDTH(DW)) bus ();

  run_splitter_2 #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .RUN_LEN(RL), .DEPTH(DP)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: expected contents of each output, built from the run rules.
  logic [DW-1:0] exp1[$];
  logic [DW-1:0] exp2[$];
  logic [DW-1:0] src[$];
  logic [KW-1:0] got1[$];
  logic [KW-1:0] got2[$];
  int m_active;
  int m_count;

  function automatic void model_clear();
    exp1.delete(); exp2.delete(); src.delete(); got1.delete(); got2.delete();
    m_active = 1; m_count = 0;
  endfunction

  function automatic void model_push(input logic [DW-1:0] d);
    if (m_active == 1) exp1.push_back(d); else exp2.push_back(d);
    if (d[KW-1:0] == '0) begin
      m_active = 3 - m_active; m_count = 0;
    end else begin
      m_count++;
      if (m_count == RL) begin
        if (m_active == 1) exp1.push_back('0); else exp2.push_back('0);
        m_active = 3 - m_active; m_count = 0;
      end
    end
  endfunction

  function automatic logic [DW-1:0] mk(input logic [KW-1:0] k);
    logic [DW-1:0] d;
    d = {$urandom, 16'($urandom), k};
    if (k == '0) d = '0;
    return d;
  endfunction

  function automatic bit same_q(input logic [KW-1:0] a[$], input logic [KW-1:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string fmt_q(input logic [KW-1:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  task automatic tick(input bit wr, input logic [DW-1:0] d, input bit r1, input bit r2);
    bus.i_write = wr; bus.i_data = d; bus.i_fifo_1_read = r1; bus.i_fifo_2_read = r2;
    @(posedge clk); #1;
    bus.i_write = 1'b0; bus.i_fifo_1_read = 1'b0; bus.i_fifo_2_read = 1'b0;
  endtask

  task automatic do_reset();
    bus.i_write = 1'b0; bus.i_data = '0; bus.i_fifo_1_read = 1'b0; bus.i_fifo_2_read = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_clear();
  endtask

  // Streams src honouring ready, pops outputs with the given probabilities
  // and compares every popped head against the model.
  task automatic pump(input int p1, input int p2, input int max_cycles, input bit fixed);
    int cyc = 0;
    bit wr, r1, r2;
    logic [DW-1:0] d;
    while (1) begin
      if (fixed && cyc >= max_cycles) break;
      if (!fixed && src.size() == 0 && (p1 == 0 || exp1.size() == 0) &&
          (p2 == 0 || exp2.size() == 0)) break;
      if (!fixed && cyc >= max_cycles) begin
        n_checks++; n_err++;
        $display("FAIL pump_timeout: src=%0d exp1=%0d exp2=%0d left after %0d cycles",
                 src.size(), exp1.size(), exp2.size(), cyc);
        break;
      end
      wr = (src.size() > 0) && bus.o_ready;
      d  = '0;
      if (wr) begin d = src.pop_front(); model_push(d); end
      r1 = !bus.o_fifo_1_empty && (p1 > 0) && ($urandom_range(1, 100) <= p1);
      r2 = !bus.o_fifo_2_empty && (p2 > 0) && ($urandom_range(1, 100) <= p2);
      if (r1) begin
        n_checks++;
        if (exp1.size() == 0) begin
          n_err++; $display("FAIL fifo1_extra: got %h, expected nothing", bus.o_fifo_1);
        end else begin
          if (bus.o_fifo_1 !== exp1[0]) begin
            n_err++; $display("FAIL fifo1_data: got %h, expected %h", bus.o_fifo_1, exp1[0]);
          end
          void'(exp1.pop_front());
        end
        got1.push_back(bus.o_fifo_1[KW-1:0]);
      end
      if (r2) begin
        n_checks++;
        if (exp2.size() == 0) begin
          n_err++; $display("FAIL fifo2_extra: got %h, expected nothing", bus.o_fifo_2);
        end else begin
          if (bus.o_fifo_2 !== exp2[0]) begin
            n_err++; $display("FAIL fifo2_data: got %h, expected %h", bus.o_fifo_2, exp2[0]);
          end
          void'(exp2.pop_front());
        end
        got2.push_back(bus.o_fifo_2[KW-1:0]);
      end
      tick(wr, d, r1, r2);
      cyc++;
    end
  endtask

  task automatic test_reset();
    bus.i_write = 1'b0; bus.i_data = '0; bus.i_fifo_1_read = 1'b0; bus.i_fifo_2_read = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b, expected 0", bus.o_ready); end
    n_checks++; if (bus.o_fifo_1_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty1: got %b, expected 1", bus.o_fifo_1_empty); end
    n_checks++; if (bus.o_fifo_2_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty2: got %b, expected 1", bus.o_fifo_2_empty); end
    n_checks++; if (bus.o_fifo_1 !== '0 || bus.o_fifo_2 !== '0) begin n_err++; $display("FAIL rst_data: got %h/%h, expected 0/0", bus.o_fifo_1, bus.o_fifo_2); end
    n_checks++; if (bus.o_overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b, expected 0", bus.o_overrun); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL rel_ready_early: got %b, expected 0", bus.o_ready); end
    @(posedge clk); #1;
    n_checks++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %b, expected 1", bus.o_ready); end
    model_clear();
  endtask

  task automatic test_basic();
    logic [KW-1:0] e1[$];
    logic [KW-1:0] e2[$];
    do_reset();
    for (int k = 1; k <= 9; k++) src.push_back(mk(KW'(k)));
    pump(100, 100, 200, 1'b0);
    e1 = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd9};
    e2 = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd0};
    n_checks++; if (!same_q(got1, e1)) begin n_err++; $display("FAIL basic_seq1: got %s expected %s", fmt_q(got1), fmt_q(e1)); end
    n_checks++; if (!same_q(got2, e2)) begin n_err++; $display("FAIL basic_seq2: got %s expected %s", fmt_q(got2), fmt_q(e2)); end
  endtask

  task automatic test_backpressure();
    logic [KW-1:0] e1[$];
    logic [KW-1:0] e2[$];
    do_reset();
    for (int k = 1; k <= 12; k++) src.push_back(mk(KW'(k)));
    pump(0, 100, 20, 1'b1);
    n_checks++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b, expected 0", bus.o_ready); end
    n_checks++; if (bus.o_fifo_1_empty !== 1'b0 || bus.o_fifo_1[KW-1:0] !== 16'd1) begin
      n_err++; $display("FAIL bp_head1: got empty=%b key=%0d, expected empty=0 key=1", bus.o_fifo_1_empty, bus.o_fifo_1[KW-1:0]); end
    n_checks++; if (bus.o_fifo_2_empty !== 1'b1) begin n_err++; $display("FAIL bp_empty2: got %b, expected 1", bus.o_fifo_2_empty); end
    pump(100, 100, 300, 1'b0);
    e1 = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd9, 16'd10, 16'd11, 16'd12, 16'd0};
    e2 = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd0};
    n_checks++; if (!same_q(got1, e1)) begin n_err++; $display("FAIL bp_seq1: got %s expected %s", fmt_q(got1), fmt_q(e1)); end
    n_checks++; if (!same_q(got2, e2)) begin n_err++; $display("FAIL bp_seq2: got %s expected %s", fmt_q(got2), fmt_q(e2)); end
    n_checks++; if (bus.o_overrun !== 1'b0) begin n_err++; $display("FAIL bp_overrun: got %b, expected 0", bus.o_overrun); end
  endtask

  task automatic test_early_term();
    logic [KW-1:0] e1[$];
    do_reset();
    src.push_back(mk(16'd1)); src.push_back(mk(16'd2));
    src.push_back(mk(16'd0)); src.push_back(mk(16'd3));
    pump(100, 0, 100, 1'b0);
    repeat (4) tick(1'b0, '0, 1'b0, 1'b0);
    e1 = '{16'd1, 16'd2, 16'd0};
    n_checks++; if (!same_q(got1, e1)) begin n_err++; $display("FAIL early_seq1: got %s expected %s", fmt_q(got1), fmt_q(e1)); end
    n_checks++; if (bus.o_fifo_1_empty !== 1'b1) begin n_err++; $display("FAIL early_no_extra: empty1 got %b, expected 1", bus.o_fifo_1_empty); end
    n_checks++; if (bus.o_fifo_2_empty !== 1'b0 || bus.o_fifo_2[KW-1:0] !== 16'd3 || exp2.size() != 1 || bus.o_fifo_2 !== exp2[0]) begin
      n_err++; $display("FAIL early_head2: got empty=%b key=%0d, expected empty=0 key=3", bus.o_fifo_2_empty, bus.o_fifo_2[KW-1:0]); end
  endtask

  task automatic test_empty_read();
    logic [DW-1:0] d;
    do_reset();
    src.push_back(mk(16'd0));
    pump(100, 0, 100, 1'b0);
    repeat (3) tick(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (bus.o_fifo_2_empty !== 1'b1) begin n_err++; $display("FAIL eread_empty: got %b, expected 1", bus.o_fifo_2_empty); end
    d = mk(16'd5);
    model_push(d);
    tick(1'b1, d, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (bus.o_fifo_2_empty !== 1'b0 || bus.o_fifo_2 !== d) begin
      n_err++; $display("FAIL eread_head: got empty=%b data=%h, expected empty=0 data=%h", bus.o_fifo_2_empty, bus.o_fifo_2, d); end
    tick(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (bus.o_fifo_2_empty !== 1'b1) begin n_err++; $display("FAIL eread_count1: empty got %b, expected 1", bus.o_fifo_2_empty); end
  endtask

  task automatic test_random();
    logic [KW-1:0] k;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      k = ($urandom_range(0, 7) == 0) ? '0 : KW'($urandom_range(1, 65535));
      src.push_back(mk(k));
    end
    pump(60, 60, 3000, 1'b0);
    n_checks++; if (exp1.size() != 0 || exp2.size() != 0) begin
      n_err++; $display("FAIL rand_left: got %0d/%0d beats undelivered, expected 0/0", exp1.size(), exp2.size()); end
    n_checks++; if (bus.o_overrun !== 1'b0) begin n_err++; $display("FAIL rand_overrun: got %b, expected 0", bus.o_overrun); end
  endtask

  task automatic test_overrun();
    int k = 1;
    bit fell = 1'b0;
    do_reset();
    bus.i_write = 1'b1;
    for (int i = 0; i < 30 && !fell; i++) begin
      bus.i_data = mk(KW'(k)); k++;
      @(posedge clk); #1;
      if (!bus.o_ready) fell = 1'b1;
    end
    n_checks++; if (!fell) begin n_err++; $display("FAIL ovr_ready_fall: ready got 1, expected 0 within 30 cycles"); end
    repeat (2) begin bus.i_data = mk(KW'(k)); k++; @(posedge clk); #1; end
    n_checks++; if (bus.o_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_grace: got %b, expected 0", bus.o_overrun); end
    repeat (6) begin bus.i_data = mk(KW'(k)); k++; @(posedge clk); #1; end
    n_checks++; if (bus.o_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b, expected 1", bus.o_overrun); end
    bus.i_write = 1'b0;
    repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (bus.o_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b, expected 1", bus.o_overrun); end
    rst_n = 1'b0;
    #2;
    n_checks++; if (bus.o_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b, expected 0", bus.o_overrun); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_clear();
  endtask

  task automatic test_reset_midrun();
    logic [DW-1:0] d;
    logic [KW-1:0] e1[$];
    do_reset();
    d = mk(16'd1); tick(1'b1, d, 1'b0, 1'b0);
    d = mk(16'd2); tick(1'b1, d, 1'b0, 1'b0);
    repeat (2) tick(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (bus.o_fifo_1_empty !== 1'b0) begin n_err++; $display("FAIL mid_pre: empty1 got %b, expected 0", bus.o_fifo_1_empty); end
    rst_n = 1'b0;
    #2;
    n_checks++; if (bus.o_fifo_1_empty !== 1'b1 || bus.o_fifo_2_empty !== 1'b1) begin
      n_err++; $display("FAIL mid_empty: got %b/%b, expected 1/1", bus.o_fifo_1_empty, bus.o_fifo_2_empty); end
    n_checks++; if (bus.o_ready !== 1'b0 || bus.o_overrun !== 1'b0) begin
      n_err++; $display("FAIL mid_ready_ovr: got %b/%b, expected 0/0", bus.o_ready, bus.o_overrun); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_clear();
    d = mk(16'd7); model_push(d);
    tick(1'b1, d, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (bus.o_fifo_1_empty !== 1'b0 || bus.o_fifo_1 !== d) begin
      n_err++; $display("FAIL mid_head7: got empty=%b data=%h, expected empty=0 data=%h", bus.o_fifo_1_empty, bus.o_fifo_1, d); end
    for (int k = 8; k <= 10; k++) src.push_back(mk(KW'(k)));
    pump(100, 100, 100, 1'b0);
    e1 = '{16'd7, 16'd8, 16'd9, 16'd10, 16'd0};
    n_checks++; if (!same_q(got1, e1)) begin n_err++; $display("FAIL mid_seq1: got %s expected %s", fmt_q(got1), fmt_q(e1)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_early_term();
    test_empty_read();
    test_random();
    test_overrun();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/run_splitter_2.md
Name: run_splitter_2

Overview:
- Inverse of the two-input merge stage. Accepts one stream of DATA_WIDTH tuples on the write/ready interface that a merger drives on its output.
- Cuts the stream into runs of RUN_LEN beats and terminates each run with an all-zero beat (key 0 = end of run).
- Alternates runs between two FWFT output FIFOs. These expose the empty/read interface that a merger consumes on its inputs.
- Sits between merge passes, redistributing runs for the next pass.

Parameters:
- DATA_WIDTH, 256, tuple width.
- KEY_WIDTH, 32, key field width; key = data[KEY_WIDTH-1:0]; key 0 is reserved as the terminator.
- RUN_LEN, 8, data beats per run before a terminator is inserted (>=1).
- DEPTH, 16, entries per output FIFO (power of 2, >=4).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_data  in  DATA_WIDTH  upstream tuple
- i_write  in  1  upstream write strobe
- o_ready  out  1  registered; upstream may write
- o_fifo_1  out  DATA_WIDTH  head of output FIFO 1 (FWFT)
- o_fifo_1_empty  out  1  FIFO 1 empty
- i_fifo_1_read  in  1  pop FIFO 1
- o_fifo_2  out  DATA_WIDTH  head of output FIFO 2
- o_fifo_2_empty  out  1  FIFO 2 empty
- i_fifo_2_read  in  1  pop FIFO 2
- o_overrun  out  1  sticky: write accepted while skid full (beat dropped)

Behaviour:
- Reset (async assert, sync release):
  - o_ready=0, o_fifo_*_empty=1, o_fifo_*=0, o_overrun=0.
  - State PASS, active output = 1, beat count = 0, skid empty.
  - o_ready rises on the first clock edge after release.
- Input skid: 4-entry FIFO.
  - Every cycle with i_write=1 enqueues i_data.
  - o_ready is registered: it is 1 after an edge iff skid occupancy after that edge is <=1.
  - Upstream may keep writing for up to 2 cycles after o_ready falls, because the merger samples ready one cycle late.
  - A write into a full skid drops the beat and sets o_overrun, which holds until reset.
- FSM states PASS and TERM:
  - PASS: if skid is non-empty and the active FIFO is not full, move one beat.
    - If the beat's key is 0, it is forwarded as the terminator; active toggles and count is cleared.
    - Otherwise count increments. If count reaches RUN_LEN, go to TERM.
  - TERM: when the active FIFO is not full, enqueue an all-zero beat, toggle active, clear count, return to PASS. No skid pop in TERM.
- Latency:
  - A beat written at edge t is in the skid after t.
  - It reaches the output FIFO at edge t+1 if not blocked.
  - The corresponding o_fifo_n_empty falls after edge t+1.
- Output FIFOs:
  - FWFT: o_fifo_n shows the head while empty=0. i_fifo_n_read pops at the edge.
  - A read while empty is ignored and leaves pointers unchanged.
  - Simultaneous push and pop on a full FIFO is not allowed (FSM checks full first). On a non-full FIFO, push and pop in the same cycle keep the count constant.
  - Pointers wrap modulo DEPTH; full/empty use an extra pointer bit.
- Back-pressure: if the active FIFO is full, the FSM stalls in place. The inactive FIFO never blocks progress.
- Reset mid-run: all contents are discarded and no terminator is emitted. Upstream restarts the pass.

Decomposition:
- Shared package:
  - Terminator constant (all-zero tuple, KEY_WIDTH slice).
  - FSM state enum {PASS, TERM}.
  - Output-select encoding (SEL_1, SEL_2).
- Sub-module split_fifo: parameterised FWFT sync FIFO with async active-low reset and empty/full/count outputs.
  - Instantiated three times: skid with DEPTH=4, and the two output FIFOs with DEPTH.

Test Plan:
- RUN_LEN=4; write keys 1..8 back-to-back, both outputs read continuously -> FIFO1 pops 1,2,3,4,0; FIFO2 pops 5,6,7,8,0; key 9 then appears on FIFO1.
- RUN_LEN=4, DEPTH=4; never read FIFO1; write keys 1..12 honouring o_ready -> FIFO1 holds 1,2,3,4 (full).
  - FSM stalls in TERM, skid fills, o_ready=0 within 2 cycles.
  - Drain FIFO1 -> 0 terminator enqueued, 5..8 and 0 go to FIFO2, 9..12 go to FIFO1.
  - No loss; o_overrun=0.
- Write keys 1,2,0,3 with RUN_LEN=8 -> FIFO1 gets 1,2,0; FIFO2 head is 3; no extra terminator inserted.
- Pulse i_fifo_2_read while FIFO2 is empty, then write key 5 -> FIFO2 count becomes 1 and head is 5 (no pointer corruption).
- Hold reads off and keep i_write=1 for 8 cycles after o_ready falls -> o_overrun=1 and stays 1 until i_rst_n=0.
- Assert i_rst_n=0 mid-run after keys 1,2 -> immediately both empty=1, o_ready=0, o_overrun=0. After release, write key 7 -> it appears at FIFO1 head as the first beat of a new run.
